// File: rtl/sim_run_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : sim_run_pkg
//  Brief   : Shared types and constants for the sim_run_ctrl run-control block
//  Rev     : 1.0  initial release
// ============================================================================
package sim_run_pkg;

    // Run-control FSM states, explicitly 2 bits wide
    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_RUN   = 2'd1,
        ST_DONE  = 2'd2
    } run_state_e;

    // Default word address whose stores signal end of test
    localparam logic [31:0] DEFAULT_TOHOST_ADDR = 32'h0000_1000;

    // Exit code that a passing test writes (shifted left by one, LSB set)
    localparam int unsigned EXIT_PASS = 0;

endpackage : sim_run_pkg
`default_nettype wire

// File: rtl/sim_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : sim_run_ctrl
//  Brief   : Bring-up run controller. Sequences the core reset, bounds the
//            run with a cycle budget, and detects end of test by snooping
//            data-bus stores to the tohost address. All outputs registered.
//  Rev     : 1.0  initial release
// ============================================================================
module sim_run_ctrl
    import sim_run_pkg::*;
#(
    parameter int unsigned       RESET_CYCLES = 2,
    parameter int unsigned       MAX_CYCLES   = 200,
    parameter int unsigned       CNT_W        = 32,
    parameter int unsigned       ADDR_W       = 32,
    parameter int unsigned       DATA_W       = 32,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR  = ADDR_W'(DEFAULT_TOHOST_ADDR)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              restart,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              core_rst,
    output logic              running,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [DATA_W-2:0] exit_code,
    output logic [CNT_W-1:0]  cycle_count
);

    // State encodings as plain vectors so the state register is a simple bus
    localparam logic [1:0] c_st_reset = 2'(ST_RESET);
    localparam logic [1:0] c_st_run   = 2'(ST_RUN);
    localparam logic [1:0] c_st_done  = 2'(ST_DONE);

    // Reset counter only has to reach RESET_CYCLES-1
    localparam int unsigned c_rcnt_w = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    localparam logic [c_rcnt_w-1:0] c_rcnt_last  = c_rcnt_w'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]    c_cycle_last = CNT_W'(MAX_CYCLES - 1);
    localparam logic [DATA_W-2:0]   c_exit_pass  = (DATA_W-1)'(EXIT_PASS);

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [c_rcnt_w-1:0] r_rst_cnt;
    logic [CNT_W-1:0]    r_cycle_count;
    logic                r_core_rst;
    logic                r_running;
    logic                r_done;
    logic                r_pass;
    logic                r_timeout;
    logic [DATA_W-2:0]   r_exit_code;

    logic                w_in_reset;
    logic                w_in_run;
    logic                w_in_done;
    logic                w_store_hit;
    logic                w_rst_last;
    logic                w_budget_out;
    logic                w_restart_hit;
    logic                w_clear;

    assign w_in_reset    = (r_state == c_st_reset);
    assign w_in_run      = (r_state == c_st_run);
    assign w_in_done     = (r_state == c_st_done);

    // A terminating store has its LSB set; an even value to tohost is ignored
    assign w_store_hit   = wr_en && (wr_addr == TOHOST_ADDR) && wr_data[0];
    assign w_rst_last    = (r_rst_cnt == c_rcnt_last);
    assign w_budget_out  = (r_cycle_count == c_cycle_last);

    // restart is only meaningful once the test has finished
    assign w_restart_hit = w_in_done && restart;

    // restart behaves exactly like rst for counters and status
    assign w_clear       = rst || w_restart_hit;

    // Next-state logic; a store on the budget's last cycle still ends the
    // run through the same DONE transition, and the status block decides
    // which outcome is reported
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_reset: begin
                if (w_rst_last) begin
                    w_state_nxt = c_st_run;
                end
            end
            c_st_run: begin
                if (w_store_hit || w_budget_out) begin
                    w_state_nxt = c_st_done;
                end
            end
            c_st_done: begin
                if (restart) begin
                    w_state_nxt = c_st_reset;
                end
            end
            default: begin
                w_state_nxt = c_st_reset;
            end
        endcase
    end

    // State register; rst overrides everything
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_reset;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Reset counter: counts cycles spent in RESET, parks at its last value
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_rst_cnt <= '0;
        end else if (w_in_reset && !w_rst_last) begin
            r_rst_cnt <= r_rst_cnt + c_rcnt_w'(1);
        end
    end

    // RUN-cycle counter: advances on every RUN edge, including the one that
    // leaves RUN, and freezes in DONE
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_cycle_count <= '0;
        end else if (w_in_run) begin
            r_cycle_count <= r_cycle_count + CNT_W'(1);
        end
    end

    // End-of-test status: latched once on leaving RUN, held until cleared;
    // a terminating store takes priority over budget expiry
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_timeout   <= 1'b0;
            r_exit_code <= '0;
        end else if (w_in_run) begin
            if (w_store_hit) begin
                r_done      <= 1'b1;
                r_timeout   <= 1'b0;
                r_exit_code <= wr_data[DATA_W-1:1];
                r_pass      <= (wr_data[DATA_W-1:1] == c_exit_pass);
            end else if (w_budget_out) begin
                r_done      <= 1'b1;
                r_timeout   <= 1'b1;
                r_pass      <= 1'b0;
                r_exit_code <= '0;
            end
        end
    end

    // Core reset and running flag follow the next state so they line up with
    // the state they describe; the core is held in reset outside RUN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_core_rst <= 1'b1;
            r_running  <= 1'b0;
        end else begin
            r_core_rst <= (w_state_nxt != c_st_run);
            r_running  <= (w_state_nxt == c_st_run);
        end
    end

    assign core_rst    = r_core_rst;
    assign running     = r_running;
    assign done        = r_done;
    assign pass        = r_pass;
    assign timeout     = r_timeout;
    assign exit_code   = r_exit_code;
    assign cycle_count = r_cycle_count;

endmodule : sim_run_ctrl
`default_nettype wire

// File: tb/tb_sim_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : tb_sim_run_ctrl
//  Brief   : Directed self-checking bench for sim_run_ctrl
//  Rev     : 1.0  initial release
// ============================================================================
module tb_sim_run_ctrl;

    localparam int unsigned RESET_CYCLES = 2;
    localparam int unsigned MAX_CYCLES   = 200;
    localparam int unsigned CNT_W        = 32;
    localparam int unsigned ADDR_W       = 32;
    localparam int unsigned DATA_W       = 32;
    localparam logic [31:0] TOHOST       = 32'h0000_1000;

    logic              clk;
    logic              rst;
    logic              restart;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              core_rst;
    logic              running;
    logic              done;
    logic              pass;
    logic              timeout;
    logic [DATA_W-2:0] exit_code;
    logic [CNT_W-1:0]  cycle_count;

    int n_checks = 0;
    int n_errors = 0;

    sim_run_ctrl #(
        .RESET_CYCLES (RESET_CYCLES),
        .MAX_CYCLES   (MAX_CYCLES),
        .CNT_W        (CNT_W),
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .TOHOST_ADDR  (TOHOST)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .restart     (restart),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .core_rst    (core_rst),
        .running     (running),
        .done        (done),
        .pass        (pass),
        .timeout     (timeout),
        .exit_code   (exit_code),
        .cycle_count (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges; inputs change and outputs are sampled 1ns after
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        step(1);
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
    endtask

    // Hold rst 3 cycles, release, and wait the 2 reset edges into RUN cycle 0
    task automatic do_reset();
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        step(RESET_CYCLES);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst     = 1'b1;
        restart = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;

        // ---- Reset sequencing ----
        step(3);
        chk("rst_core_rst",  core_rst,    1);
        chk("rst_running",   running,     0);
        chk("rst_done",      done,        0);
        chk("rst_pass",      pass,        0);
        chk("rst_timeout",   timeout,     0);
        chk("rst_exit_code", exit_code,   0);
        chk("rst_cycles",    cycle_count, 0);
        rst = 1'b0;
        step(1);
        chk("seq1_core_rst", core_rst, 1);
        chk("seq1_running",  running,  0);
        step(1);
        chk("seq2_core_rst", core_rst,    0);
        chk("seq2_running",  running,     1);
        chk("seq2_cycles",   cycle_count, 0);

        // ---- Pass at RUN cycle 50 ----
        step(50);
        chk("pass_pre_cycles", cycle_count, 50);
        store(TOHOST, 32'h1);
        chk("pass_done",      done,        1);
        chk("pass_pass",      pass,        1);
        chk("pass_exit_code", exit_code,   0);
        chk("pass_cycles",    cycle_count, 51);
        chk("pass_core_rst",  core_rst,    1);
        chk("pass_running",   running,     0);
        chk("pass_timeout",   timeout,     0);
        // stores in DONE are ignored and status/counter are frozen
        store(TOHOST, 32'h7);
        step(3);
        chk("done_hold_done",  done,        1);
        chk("done_hold_pass",  pass,        1);
        chk("done_hold_exit",  exit_code,   0);
        chk("done_hold_cyc",   cycle_count, 51);
        chk("done_hold_crst",  core_rst,    1);

        // ---- Fail code at cycle 10 ----
        do_reset();
        chk("fail_start_run", running, 1);
        step(10);
        store(TOHOST, 32'h7);
        chk("fail_done",      done,        1);
        chk("fail_pass",      pass,        0);
        chk("fail_exit_code", exit_code,   3);
        chk("fail_timeout",   timeout,     0);
        chk("fail_cycles",    cycle_count, 11);

        // ---- Ignored stores then timeout ----
        do_reset();
        step(5);
        store(TOHOST, 32'h6);
        chk("ign_even_running", running, 1);
        chk("ign_even_done",    done,    0);
        store(TOHOST + 32'h4, 32'h1);
        chk("ign_addr_running", running,     1);
        chk("ign_addr_done",    done,        0);
        chk("ign_addr_cycles",  cycle_count, 7);
        step(192);
        chk("to_pre_cycles",  cycle_count, 199);
        chk("to_pre_running", running,     1);
        step(1);
        chk("to_done",      done,        1);
        chk("to_timeout",   timeout,     1);
        chk("to_pass",      pass,        0);
        chk("to_exit_code", exit_code,   0);
        chk("to_cycles",    cycle_count, 200);
        chk("to_running",   running,     0);
        chk("to_core_rst",  core_rst,    1);

        // ---- Collision: store on the budget's last cycle ----
        do_reset();
        step(199);
        chk("col_pre_cycles", cycle_count, 199);
        store(TOHOST, 32'h1);
        chk("col_done",    done,        1);
        chk("col_timeout", timeout,     0);
        chk("col_pass",    pass,        1);
        chk("col_cycles",  cycle_count, 200);

        // ---- Restart from DONE ----
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        chk("rs0_done",     done,        0);
        chk("rs0_pass",     pass,        0);
        chk("rs0_core_rst", core_rst,    1);
        chk("rs0_running",  running,     0);
        chk("rs0_cycles",   cycle_count, 0);
        step(1);
        chk("rs1_core_rst", core_rst, 1);
        chk("rs1_running",  running,  0);
        step(1);
        chk("rs2_core_rst", core_rst,    0);
        chk("rs2_running",  running,     1);
        chk("rs2_cycles",   cycle_count, 0);

        // restart outside DONE is ignored
        step(19);
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        chk("rs_ign_running", running,     1);
        chk("rs_ign_cycles",  cycle_count, 20);

        // ---- Mid-run reset at cycle 20, with a competing terminating store ----
        rst     = 1'b1;
        wr_en   = 1'b1;
        wr_addr = TOHOST;
        wr_data = 32'h5;
        step(1);
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        chk("mid_core_rst",  core_rst,    1);
        chk("mid_running",   running,     0);
        chk("mid_done",      done,        0);
        chk("mid_pass",      pass,        0);
        chk("mid_timeout",   timeout,     0);
        chk("mid_exit_code", exit_code,   0);
        chk("mid_cycles",    cycle_count, 0);
        rst = 1'b0;
        step(RESET_CYCLES);
        chk("mid_rerun_running", running,     1);
        chk("mid_rerun_cycles",  cycle_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_sim_run_ctrl
`default_nettype wire

// File: doc/sim_run_ctrl.md
# sim_run_ctrl

Synthesizable run-control block for bring-up of the `soc` top: it sequences the core reset, bounds execution with a cycle budget, and detects end-of-test by snooping data-bus stores to a `tohost` address. It generalises the fixed reset-two-cycles and run-200-cycles harness into a parametrised controller. It sits beside `soc`, drives the core reset, and exposes pass/fail/timeout status to a testbench, an FPGA LED bank or a debug UART.

## Interface
- `RESET_CYCLES`, 2: cycles `core_rst` stays high after `rst` deasserts; legal range is 1 or more.
- `MAX_CYCLES`, 200: RUN-cycle budget before timeout; legal range is 1 or more.
- `CNT_W`, 32: width of the cycle counter; must hold `MAX_CYCLES`.
- `ADDR_W`, 32: snooped address width.
- `DATA_W`, 32: snooped data width.
- `TOHOST_ADDR`, 32'h0000_1000: word address that signals end of test.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `restart`  in  1  single-cycle pulse that re-runs the test; only honoured in DONE.
- `wr_en`  in  1  data-bus store strobe from the core.
- `wr_addr`  in  ADDR_W  store address.
- `wr_data`  in  DATA_W  store data.
- `core_rst`  out  1  registered reset for the core and memories.
- `running`  out  1  high while in RUN.
- `done`  out  1  sticky; end of test reached.
- `pass`  out  1  valid when `done`; the exit code was 0.
- `timeout`  out  1  valid when `done`; the cycle budget expired.
- `exit_code`  out  DATA_W-1  `wr_data[DATA_W-1:1]` of the terminating store.
- `cycle_count`  out  CNT_W  number of RUN cycles elapsed.

## Operation
- FSM states are RESET, RUN and DONE.
- While `rst` is high:
  - The state is RESET and the reset counter is 0.
  - `core_rst`=1 and `running`=0.
  - `done`, `pass` and `timeout` are 0; `exit_code` and `cycle_count` are 0.
- RESET state:
  - The reset counter increments each cycle.
  - When it reaches `RESET_CYCLES`-1, the FSM goes to RUN.
  - `core_rst` falls on entry to RUN.
- RUN state:
  - `cycle_count` increments every cycle.
  - A terminating store is `wr_en`=1, `wr_addr`==`TOHOST_ADDR` and `wr_data[0]`=1.
  - A terminating store sends the FSM to DONE and latches `exit_code`=`wr_data>>1`, `pass`=(exit_code==0) and `timeout`=0.
  - A store to `TOHOST_ADDR` with `wr_data[0]`=0 is ignored.
  - When `cycle_count`==`MAX_CYCLES`-1 with no terminating store, the FSM goes to DONE with `timeout`=1, `pass`=0 and `exit_code`=0.
- DONE state:
  - `cycle_count` freezes.
  - Status is held until `rst` or `restart`.
  - `core_rst` is reasserted to 1 to park the core.
  - `restart`=1 returns the FSM to RESET and clears the counters and all status, as `rst` does.
- Stores seen in RESET or DONE are ignored. `restart` seen outside DONE is ignored.

## Timing
- After `rst` deasserts, `core_rst` stays high for exactly `RESET_CYCLES` rising edges.
- In the first RUN cycle, `running`=1 and `cycle_count`=0.
- A terminating store is sampled at edge N. From edge N onward, `done`=1, `running`=0 and `core_rst`=1. That is a one-cycle latency, and `cycle_count` holds the value it had at edge N+1.
- Simultaneous terminating store and budget expiry on the same edge: the store wins, with `timeout`=0 and `pass` taken from the data.
- `rst` asserted mid-RUN or mid-DONE: at the next edge every output returns to its reset value. `rst` has priority over `restart` and over stores.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `sim_run_pkg`:
  - `run_state_e` enum: RESET, RUN, DONE.
  - Default `TOHOST_ADDR` localparam.
  - Exit-code helper constant `EXIT_PASS`=0.
- Single module. No sub-module is warranted; the reset counter and `cycle_count` are inline.
- `soc` instantiates `sim_run_ctrl` and feeds `core_rst` to the core in place of raw `rst`.

## Test plan
All scenarios use RESET_CYCLES=2, MAX_CYCLES=200 and TOHOST_ADDR=0x1000.
- Reset sequencing: hold `rst` for 3 cycles, then release. Required: `core_rst` stays high for 2 more edges, then `running`=1 with `cycle_count`=0.
- Pass: a store of 0x1000 / 0x1 at RUN cycle 50. Required: the next edge gives `done`=1, `pass`=1, `exit_code`=0, `cycle_count`=51 and `core_rst`=1.
- Fail code: a store of 0x1000 / 0x7 at cycle 10. Required: `done`=1, `pass`=0, `exit_code`=3, `timeout`=0.
- Ignored stores:
  - A store of 0x1000 / 0x6 at cycle 5 must be ignored, with `running` staying 1.
  - A store of 0x1004 / 0x1 at cycle 6 must also be ignored.
  - With no further stores, a timeout follows: `done`=1, `timeout`=1, `cycle_count`=200.
- Collision: a terminating store 0x1000 / 0x1 on the cycle where `cycle_count`=199. Required: `timeout`=0 and `pass`=1.
- Restart and mid-run reset:
  - A `restart` pulse in DONE must give `done`=0 and `core_rst`=1 for 2 edges, then RUN with `cycle_count`=0.
  - `rst` asserted at RUN cycle 20 must restore all reset values on the next edge.
